// File: rtl/qed_pkg.sv
// Shared QED scheduler definitions: FSM state type, RISC-V opcode constants, NOP encoding
// and the classifier that decides which originals get a duplicate.
// No ports; imported by qed_dup_xform and qed_issue_scheduler.
package qed_pkg;

    typedef enum logic [1:0] {
        ORIG = 2'd0,
        DUP  = 2'd1,
        DONE = 2'd2
    } qed_state_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;
    localparam logic [6:0] OP_NOP   = 7'h7F;

    localparam logic [31:0] QED_NOP = 32'h0000_007F;

    // Only register/memory data-flow instructions get a duplicate; control flow,
    // AUIPC (PC-relative), SYSTEM and the NOP filler are issued once.
    function automatic logic is_dupable(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LUI, OP_LW, OP_SW:            return 1'b1;
            OP_B, OP_JAL, OP_AUIPC, OP_SYS, OP_NOP:      return 1'b0;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/qed_dup_xform.sv
// Combinational original->duplicate transform: remaps the register fields each format uses
// into the duplicate register bank and moves LW/SW into the duplicate memory half.
// Ports: instr (32b original in), dup (32b duplicate out). Zero latency, no flow control.
module qed_dup_xform
    import qed_pkg::*;
#(
    parameter int REG_OFFSET     = 16,
    parameter int MEM_OFFSET_BIT = 6
) (
    input  logic [31:0] instr,
    output logic [31:0] dup
);

    localparam logic [4:0] OFS = 5'(REG_OFFSET);
    // I-immediate bit k sits at instr[20+k]; for the S-immediate, bits 11:5 sit at
    // instr[31:25], so bit k (k>=5) is also at instr[20+k].
    localparam int IMM_BIT = 20 + MEM_OFFSET_BIT;

    // x0 stays x0 in both streams so hardwired-zero semantics are preserved.
    function automatic logic [4:0] remap(input logic [4:0] r);
        return (r == 5'd0) ? r : r + OFS;
    endfunction

    always_comb begin
        dup = instr;
        case (instr[6:0])
            OP_R: begin
                dup[11:7]  = remap(instr[11:7]);
                dup[19:15] = remap(instr[19:15]);
                dup[24:20] = remap(instr[24:20]);
            end
            OP_I: begin
                dup[11:7]  = remap(instr[11:7]);
                dup[19:15] = remap(instr[19:15]);
            end
            OP_LUI: begin
                dup[11:7]  = remap(instr[11:7]);
            end
            OP_LW: begin
                dup[11:7]    = remap(instr[11:7]);
                dup[19:15]   = remap(instr[19:15]);
                dup[IMM_BIT] = 1'b1;
            end
            OP_SW: begin
                dup[19:15]   = remap(instr[19:15]);
                dup[24:20]   = remap(instr[24:20]);
                dup[IMM_BIT] = 1'b1;
            end
            default: dup = instr;
        endcase
    end

endmodule

// File: rtl/qed_issue_scheduler.sv
// QED issue scheduler: ORIG phase passes instructions through and buffers duplicables,
// DUP phase replays them transformed, DONE emits NOPs with qed_ready held until reset.
// Latency 1 cycle input->qed_ifu_instruction; stall_IF freezes every register incl. FIFO.
// Ports: clk, reset (sync, active-high), ifu_qed_instruction[31:0], exec_dup, stall_IF,
//        qed_ifu_instruction[31:0], qed_vld_out, qed_ready, qed_fifo_full.
// Optional macro QED_SCHED_ASSERT_EN embeds SVA properties; behaviour is unchanged.
module qed_issue_scheduler
    import qed_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int REG_OFFSET     = 16,
    parameter int MEM_OFFSET_BIT = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ifu_qed_instruction,
    input  logic        exec_dup,
    input  logic        stall_IF,
    output logic [31:0] qed_ifu_instruction,
    output logic        qed_vld_out,
    output logic        qed_ready,
    output logic        qed_fifo_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1) + 1;

    qed_state_e      state, state_nxt;
    logic [31:0]     mem [DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic [AW:0]     occ, occ_post;
    logic [CW-1:0]   orig_cnt, dup_cnt, orig_nxt, dup_nxt;
    logic            push, pop, full;
    logic [31:0]     head_dup, instr_nxt;
    logic            ready_nxt;

    // Wrap-bit pointers: equal -> empty, MSB-only difference -> full.
    assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign occ           = wr_ptr - rd_ptr;
    assign qed_fifo_full = full;

    assign push     = (state == ORIG) && !stall_IF && is_dupable(ifu_qed_instruction[6:0]);
    assign pop      = (state == DUP) && !stall_IF;
    assign occ_post = occ + (AW+1)'(push);
    assign orig_nxt = orig_cnt + CW'(push);
    assign dup_nxt  = dup_cnt + CW'(pop);

    qed_dup_xform #(
        .REG_OFFSET     (REG_OFFSET),
        .MEM_OFFSET_BIT (MEM_OFFSET_BIT)
    ) u_xform (
        .instr (mem[rd_ptr[AW-1:0]]),
        .dup   (head_dup)
    );

    always_comb begin
        state_nxt = state;
        instr_nxt = QED_NOP;
        case (state)
            ORIG: begin
                instr_nxt = ifu_qed_instruction;
                // Decide on post-push occupancy so the current input is buffered first;
                // exec_dup alone never leaves ORIG with nothing to replay.
                if ((exec_dup && occ_post != '0) || occ_post == (AW+1)'(DEPTH))
                    state_nxt = DUP;
            end
            DUP: begin
                instr_nxt = head_dup;
                if (occ == (AW+1)'(1))
                    state_nxt = DONE;
            end
            DONE:    instr_nxt = QED_NOP;
            default: state_nxt = ORIG;
        endcase
        // Raised on the same edge as the final duplicate so the check sees a completed pair set.
        ready_nxt = qed_ready ||
                    (state_nxt == DONE && orig_nxt == dup_nxt && orig_nxt != '0);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= ORIG;
        else if (!stall_IF)
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            orig_cnt            <= '0;
            dup_cnt             <= '0;
            qed_ifu_instruction <= QED_NOP;
            qed_vld_out         <= 1'b0;
            qed_ready           <= 1'b0;
        end else if (!stall_IF) begin
            wr_ptr              <= wr_ptr + (AW+1)'(push);
            rd_ptr              <= rd_ptr + (AW+1)'(pop);
            orig_cnt            <= orig_nxt;
            dup_cnt             <= dup_nxt;
            qed_ifu_instruction <= instr_nxt;
            qed_vld_out         <= 1'b1;
            qed_ready           <= ready_nxt;
        end
    end

    // Storage is not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[wr_ptr[AW-1:0]] <= ifu_qed_instruction;
    end

`ifdef QED_SCHED_ASSERT_EN
    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
        push |-> !full);
    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
        pop |-> (wr_ptr != rd_ptr));
    a_ready_counts: assert property (@(posedge clk) disable iff (reset)
        qed_ready |-> (orig_cnt == dup_cnt && orig_cnt != '0));
    a_done_sticky: assert property (@(posedge clk) disable iff (reset)
        (state == DONE) |=> (state == DONE));
    a_stall_hold: assert property (@(posedge clk) disable iff (reset)
        stall_IF |=> ($stable(qed_ifu_instruction) && $stable(qed_vld_out) &&
                      $stable(qed_ready) && $stable(qed_fifo_full)));
`else
    // Plain build: no embedded properties.
`endif

endmodule

// File: tb/tb_qed_issue_scheduler.sv
// Scoreboard bench for qed_issue_scheduler: each stimulus cycle queues the expected
// registered outputs; a negedge monitor pops and compares (or checks hold under stall).
module tb_qed_issue_scheduler;

    localparam logic [31:0] NOP    = 32'h0000007F;
    localparam logic [31:0] ADD1   = 32'h003100B3, D_ADD1 = 32'h013908B3;
    localparam logic [31:0] LW4    = 32'h00402083, D_LW4  = 32'h04402883;
    localparam logic [31:0] ADDI   = 32'h00730293, D_ADDI = 32'h007B0A93;
    localparam logic [31:0] LUI    = 32'h123451B7, D_LUI  = 32'h123459B7;
    localparam logic [31:0] SW     = 32'h0020A423, D_SW   = 32'h0528A423;
    localparam logic [31:0] ADD0   = 32'h00520033, D_ADD0 = 32'h015A0033;
    localparam logic [31:0] LW7    = 32'h00012383, D_LW7  = 32'h04092B83;
    localparam logic [31:0] XORI   = 32'hFFF7C793, D_XORI = 32'hFFFFCF93;
    localparam logic [31:0] LUI0   = 32'h00001037, D_LUI0 = 32'h00001037;
    localparam logic [31:0] BEQ    = 32'h00208463;
    localparam logic [31:0] JAL    = 32'h0100006F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ifu_qed_instruction = NOP;
    logic        exec_dup = 1'b0;
    logic        stall_IF = 1'b0;
    logic [31:0] qed_ifu_instruction;
    logic        qed_vld_out, qed_ready, qed_fifo_full;

    always #5 clk = ~clk;

    qed_issue_scheduler dut (
        .clk                 (clk),
        .reset               (reset),
        .ifu_qed_instruction (ifu_qed_instruction),
        .exec_dup            (exec_dup),
        .stall_IF            (stall_IF),
        .qed_ifu_instruction (qed_ifu_instruction),
        .qed_vld_out         (qed_vld_out),
        .qed_ready           (qed_ready),
        .qed_fifo_full       (qed_fifo_full)
    );

    typedef struct packed {
        logic        hold;
        logic [31:0] instr;
        logic        vld;
        logic        rdy;
        logic        full;
    } exp_t;

    exp_t        sb_q[$];
    string       tag_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        mon_e;
    string       mon_tag;
    logic [34:0] mon_cur;
    logic [34:0] mon_last = '0;

    // Monitor: one expectation per clock edge the stimulus drove.
    initial forever begin
        @(negedge clk);
        if (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_tag = tag_q.pop_front();
            mon_cur = {qed_ifu_instruction, qed_vld_out, qed_ready, qed_fifo_full};
            n_cmp++;
            if (mon_e.hold) begin
                if (mon_cur !== mon_last) begin
                    n_bad++;
                    $display("FAIL %s: outputs moved under stall, got instr=%h vld=%b rdy=%b full=%b, held instr=%h vld=%b rdy=%b full=%b",
                             mon_tag, mon_cur[34:3], mon_cur[2], mon_cur[1], mon_cur[0],
                             mon_last[34:3], mon_last[2], mon_last[1], mon_last[0]);
                end
            end else if (mon_cur !== {mon_e.instr, mon_e.vld, mon_e.rdy, mon_e.full}) begin
                n_bad++;
                $display("FAIL %s: got instr=%h vld=%b rdy=%b full=%b, expected instr=%h vld=%b rdy=%b full=%b",
                         mon_tag, mon_cur[34:3], mon_cur[2], mon_cur[1], mon_cur[0],
                         mon_e.instr, mon_e.vld, mon_e.rdy, mon_e.full);
            end
            mon_last = mon_cur;
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input string tag, input logic rst, input logic [31:0] ins,
                        input logic exd, input logic stl, input logic hold,
                        input logic [31:0] e_ins, input logic e_vld, input logic e_rdy,
                        input logic e_full);
        exp_t e;
        @(negedge clk);
        #1;
        reset               = rst;
        ifu_qed_instruction = ins;
        exec_dup            = exd;
        stall_IF            = stl;
        e.hold  = hold;
        e.instr = e_ins;
        e.vld   = e_vld;
        e.rdy   = e_rdy;
        e.full  = e_full;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic do_reset(input string tag);
        step(tag, 1'b1, ADD1, 1'b1, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 1'b0);
    endtask

    // Normal unstalled cycle: expected instr, ready, full; vld is always 1.
    task automatic go(input string tag, input logic [31:0] ins, input logic exd,
                      input logic [31:0] e_ins, input logic e_rdy, input logic e_full);
        step(tag, 1'b0, ins, exd, 1'b0, 1'b0, e_ins, 1'b1, e_rdy, e_full);
    endtask

    task automatic stall(input string tag, input logic [31:0] ins);
        step(tag, 1'b0, ins, 1'b1, 1'b1, 1'b1, NOP, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: ADD + exec_dup
        do_reset("t1_reset");
        go("t1_orig_add",  ADD1, 1'b1, ADD1,   1'b0, 1'b0);
        go("t1_dup_add",   NOP,  1'b0, D_ADD1, 1'b1, 1'b0);
        go("t1_done",      NOP,  1'b0, NOP,    1'b1, 1'b0);

        // 2: LW duplicate sets imm bit 6
        do_reset("t2_reset");
        go("t2_orig_lw",   LW4,  1'b1, LW4,    1'b0, 1'b0);
        go("t2_dup_lw",    ADD1, 1'b1, D_LW4,  1'b1, 1'b0);
        go("t2_done",      ADD1, 1'b0, NOP,    1'b1, 1'b0);

        // 3: fill the FIFO, automatic DUP, FIFO-order replay; inputs ignored in DUP
        do_reset("t3_reset");
        go("t3_o1", ADD1, 1'b0, ADD1, 1'b0, 1'b0);
        go("t3_o2", ADDI, 1'b0, ADDI, 1'b0, 1'b0);
        go("t3_o3", LUI,  1'b0, LUI,  1'b0, 1'b0);
        go("t3_o4", SW,   1'b0, SW,   1'b0, 1'b0);
        go("t3_o5", ADD0, 1'b0, ADD0, 1'b0, 1'b0);
        go("t3_o6", LW7,  1'b0, LW7,  1'b0, 1'b0);
        go("t3_o7", XORI, 1'b0, XORI, 1'b0, 1'b0);
        go("t3_o8_full", LUI0, 1'b0, LUI0, 1'b0, 1'b1);
        go("t3_d1", ADD1, 1'b1, D_ADD1, 1'b0, 1'b0);
        go("t3_d2", ADD1, 1'b0, D_ADDI, 1'b0, 1'b0);
        go("t3_d3", SW,   1'b1, D_LUI,  1'b0, 1'b0);
        go("t3_d4", SW,   1'b0, D_SW,   1'b0, 1'b0);
        go("t3_d5", LW4,  1'b0, D_ADD0, 1'b0, 1'b0);
        go("t3_d6", LW4,  1'b0, D_LW7,  1'b0, 1'b0);
        go("t3_d7", NOP,  1'b0, D_XORI, 1'b0, 1'b0);
        go("t3_d8_ready", NOP, 1'b0, D_LUI0, 1'b1, 1'b0);
        go("t3_done", ADD1, 1'b1, NOP, 1'b1, 1'b0);

        // 4: non-duplicable instructions issued but not buffered; exec_dup on empty ignored
        do_reset("t4_reset");
        go("t4_beq_exd_empty", BEQ,  1'b1, BEQ,  1'b0, 1'b0);
        go("t4_add1",          ADD1, 1'b0, ADD1, 1'b0, 1'b0);
        go("t4_jal",           JAL,  1'b0, JAL,  1'b0, 1'b0);
        go("t4_nop",           NOP,  1'b0, NOP,  1'b0, 1'b0);
        go("t4_add0_exd",      ADD0, 1'b1, ADD0, 1'b0, 1'b0);
        go("t4_dup1",          BEQ,  1'b0, D_ADD1, 1'b0, 1'b0);
        go("t4_dup2_ready",    JAL,  1'b0, D_ADD0, 1'b1, 1'b0);
        go("t4_done",          ADD1, 1'b1, NOP,    1'b1, 1'b0);
        go("t4_done_sticky",   LW4,  1'b1, NOP,    1'b1, 1'b0);

        // 5: stall in ORIG (no push) and for 3 cycles mid-DUP
        do_reset("t5_reset");
        go("t5_o1", ADD1, 1'b0, ADD1, 1'b0, 1'b0);
        go("t5_o2", ADDI, 1'b0, ADDI, 1'b0, 1'b0);
        stall("t5_orig_stall", SW);
        go("t5_o3", LUI,  1'b1, LUI,  1'b0, 1'b0);
        go("t5_d1", NOP,  1'b0, D_ADD1, 1'b0, 1'b0);
        stall("t5_stall1", XORI);
        stall("t5_stall2", XORI);
        stall("t5_stall3", XORI);
        go("t5_d2", NOP,  1'b0, D_ADDI, 1'b0, 1'b0);
        go("t5_d3_ready", NOP, 1'b0, D_LUI, 1'b1, 1'b0);
        go("t5_done", NOP, 1'b0, NOP, 1'b1, 1'b0);

        // 6: reset mid-DUP with 3 entries left discards them
        do_reset("t6_reset");
        go("t6_o1", ADD1, 1'b0, ADD1, 1'b0, 1'b0);
        go("t6_o2", ADDI, 1'b0, ADDI, 1'b0, 1'b0);
        go("t6_o3", LUI,  1'b0, LUI,  1'b0, 1'b0);
        go("t6_o4", LW7,  1'b1, LW7,  1'b0, 1'b0);
        go("t6_d1", NOP,  1'b0, D_ADD1, 1'b0, 1'b0);
        do_reset("t6_reset_mid_dup");
        go("t6_new_orig", ADD0, 1'b1, ADD0, 1'b0, 1'b0);
        go("t6_new_dup_ready", NOP, 1'b0, D_ADD0, 1'b1, 1'b0);
        go("t6_done", NOP, 1'b0, NOP, 1'b1, 1'b0);

        @(negedge clk);
        @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
